// File: rtl/uart_tx_arbiter_if.sv
// Channel-side and UART-side signals of the UART TX arbiter.
// The arbiter connects through the slave modport; the source/sink
// environment uses the master modport.
interface uart_tx_arbiter_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
);
    logic                  tx_full;
    logic [N_CH*8-1:0]     ch_data;
    logic [N_CH-1:0]       ch_en;
    logic                  mode;
    logic                  wr_uart;
    logic [7:0]            w_data;
    logic [CNT_W-1:0]      sent_cnt;

    modport master (
        output tx_full, ch_data, ch_en, mode,
        input  wr_uart, w_data, sent_cnt
    );

    modport slave (
        input  tx_full, ch_data, ch_en, mode,
        output wr_uart, w_data, sent_cnt
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding N_CH byte channels into one UART TX FIFO.
// Cyclic mode sends every enabled channel in turn; on-change mode sends a
// channel only when its payload differs from the last byte sent on it.
// Back-pressure holds the pointer on the eligible channel so none is skipped.
module uart_tx_arbiter #(
    parameter int N_CH       = 4,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_arbiter_if.slave     bus
);
    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [1:0] ST_SELECT = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    localparam logic [7:0]       GAP_LOAD = 8'(GAP_CYCLES);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_CH - 1);

    logic [1:0]          state_q,     state_d;
    logic [PTR_W-1:0]    ptr_q,       ptr_d;
    logic                wr_uart_q,   wr_uart_d;
    logic [7:0]          w_data_q,    w_data_d;
    logic [CNT_W-1:0]    sent_cnt_q,  sent_cnt_d;
    logic [N_CH*8-1:0]   last_sent_q, last_sent_d;
    logic [N_CH-1:0]     sent_vld_q,  sent_vld_d;
    logic [7:0]          gap_cnt_q,   gap_cnt_d;

    logic [7:0]          cur_byte_s;
    logic                eligible_s;

    // Pointer advance with wrap from the last channel back to channel 0.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Eligibility of the channel under the pointer, from live inputs.
    always_comb begin
        cur_byte_s = bus.ch_data[{ptr_q, 3'b000} +: 8];
        eligible_s = bus.ch_en[ptr_q] &&
                     (!bus.mode || !sent_vld_q[ptr_q] ||
                      (cur_byte_s != last_sent_q[{ptr_q, 3'b000} +: 8]));
    end

    // Next-state logic for the SELECT / WRITE / GAP sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        wr_uart_d   = 1'b0;
        w_data_d    = w_data_q;
        sent_cnt_d  = sent_cnt_q;
        last_sent_d = last_sent_q;
        sent_vld_d  = sent_vld_q;
        gap_cnt_d   = gap_cnt_q;

        case (state_q)
            ST_SELECT: begin
                if (eligible_s) begin
                    if (!bus.tx_full) begin
                        // Capture now so the strobe and byte appear together next cycle.
                        w_data_d  = cur_byte_s;
                        wr_uart_d = 1'b1;
                        state_d   = ST_WRITE;
                    end else begin
                        // FIFO full: stay on this channel until it drains.
                        state_d = ST_SELECT;
                    end
                end else begin
                    ptr_d = ptr_next(ptr_q);
                end
            end
            ST_WRITE: begin
                last_sent_d[{ptr_q, 3'b000} +: 8] = w_data_q;
                sent_vld_d[ptr_q]                 = 1'b1;
                sent_cnt_d                        = sent_cnt_q + CNT_W'(1);
                ptr_d                             = ptr_next(ptr_q);
                gap_cnt_d                         = GAP_LOAD;
                if (GAP_LOAD == 8'd0) begin
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - 8'd1;
                if (gap_cnt_q <= 8'd1) begin
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_SELECT;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SELECT;
            ptr_q       <= {PTR_W{1'b0}};
            wr_uart_q   <= 1'b0;
            w_data_q    <= 8'h00;
            sent_cnt_q  <= {CNT_W{1'b0}};
            last_sent_q <= {(N_CH*8){1'b0}};
            sent_vld_q  <= {N_CH{1'b0}};
            gap_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wr_uart_q   <= wr_uart_d;
            w_data_q    <= w_data_d;
            sent_cnt_q  <= sent_cnt_d;
            last_sent_q <= last_sent_d;
            sent_vld_q  <= sent_vld_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign bus.wr_uart  = wr_uart_q;
    assign bus.w_data   = w_data_q;
    assign bus.sent_cnt = sent_cnt_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: two instances (no gap and a
// three-cycle gap) share stimulus; a slot-based reference model predicts
// each strobe, its byte and cycle, and a negedge monitor checks outputs.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int CW = 16;

    typedef struct {
        logic [7:0] b;
        int         cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_full;
    logic [N*8-1:0] ch_data;
    logic [N-1:0]  ch_en;
    logic          mode;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_CH(N), .CNT_W(CW)) if0 ();
    uart_tx_arbiter_if #(.N_CH(N), .CNT_W(CW)) if1 ();

    assign if0.tx_full = tx_full;
    assign if0.ch_data = ch_data;
    assign if0.ch_en   = ch_en;
    assign if0.mode    = mode;
    assign if1.tx_full = tx_full;
    assign if1.ch_data = ch_data;
    assign if1.ch_en   = ch_en;
    assign if1.mode    = mode;

    uart_tx_arbiter #(.N_CH(N), .GAP_CYCLES(0), .CNT_W(CW)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    uart_tx_arbiter #(.N_CH(N), .GAP_CYCLES(3), .CNT_W(CW)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   started = 1'b0;
    exp_t sbq [2][$];
    int   mptr [2];
    int   mnext [2];
    int   mcnt [2];
    bit   mpend [2];
    logic [7:0] mwd [2];
    logic [7:0] mlast [2][N];
    bit   mvld [2][N];
    int   nwr [2];

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string name, input int d, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at cycle %0d", name, d, act, exp, cyc);
        end
    endtask

    // Reference model: each evaluation slot looks at one channel; a send
    // occupies 2+gap slots, a skip occupies one, a full FIFO retries.
    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (mpend[d]) begin
                mcnt[d]++;
                mpend[d] = 1'b0;
            end
            if (rst) begin
                mptr[d]  = 0;
                mnext[d] = cyc + 1;
                mcnt[d]  = 0;
                mwd[d]   = 8'h00;
                for (int k = 0; k < N; k++) begin
                    mlast[d][k] = 8'h00;
                    mvld[d][k]  = 1'b0;
                end
                sbq[d].delete();
            end else if (cyc >= mnext[d]) begin
                logic [7:0] b;
                bit elig;
                b    = ch_data[mptr[d]*8 +: 8];
                elig = ch_en[mptr[d]] && (!mode || !mvld[d][mptr[d]] || b != mlast[d][mptr[d]]);
                if (elig && !tx_full) begin
                    sbq[d].push_back('{b: b, cyc: cyc});
                    mlast[d][mptr[d]] = b;
                    mvld[d][mptr[d]]  = 1'b1;
                    mwd[d]   = b;
                    mpend[d] = 1'b1;
                    mptr[d]  = (mptr[d] + 1) % N;
                    mnext[d] = cyc + 2 + gap_of(d);
                end else if (!elig) begin
                    mptr[d]  = (mptr[d] + 1) % N;
                    mnext[d] = cyc + 1;
                end
            end
        end
        if (rst) started = 1'b1;
    end

    // Monitor: compare strobe, byte, held data and counter every cycle.
    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                logic       wr;
                logic [7:0] wd;
                logic [CW-1:0] cnt;
                bit         exp_wr;
                wr  = (d == 0) ? if0.wr_uart  : if1.wr_uart;
                wd  = (d == 0) ? if0.w_data   : if1.w_data;
                cnt = (d == 0) ? if0.sent_cnt : if1.sent_cnt;
                exp_wr = (sbq[d].size() > 0) && (sbq[d][0].cyc <= cyc);
                chk("wr_uart", d, int'(wr), int'(exp_wr));
                if (wr) nwr[d]++;
                if (exp_wr) begin
                    if (wr) chk("strobe_byte", d, int'(wd), int'(sbq[d][0].b));
                    void'(sbq[d].pop_front());
                end
                chk("w_data", d, int'(wd), int'(mwd[d]));
                chk("sent_cnt", d, int'(cnt), mcnt[d] % (1 << CW));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int base0, base1;
        bit seen;
        rst = 1'b1; tx_full = 1'b0; mode = 1'b0; ch_en = 4'hF;
        ch_data = 32'h44332211;
        for (int d = 0; d < 2; d++) nwr[d] = 0;
        tick(3);
        chk("reset_w_data", 0, int'(if0.w_data), 0);
        chk("reset_cnt", 1, int'(if1.sent_cnt), 0);
        rst = 1'b0;

        // Cyclic, all channels.
        tick(40);
        // Only channels 0 and 2.
        ch_en = 4'b0101;
        tick(30);
        // Back-pressure for ten cycles.
        ch_en = 4'hF;
        tx_full = 1'b1;
        tick(1);
        base0 = nwr[0]; base1 = nwr[1];
        tick(9);
        chk("full_no_strobe", 0, nwr[0] - base0, 0);
        chk("full_no_strobe", 1, nwr[1] - base1, 0);
        tx_full = 1'b0;
        tick(20);

        // On-change mode after reset: one write per channel, then quiet.
        rst = 1'b1; mode = 1'b1; tick(2); rst = 1'b0;
        base0 = nwr[0]; base1 = nwr[1];
        tick(30);
        chk("mode1_initial", 0, nwr[0] - base0, N);
        chk("mode1_initial", 1, nwr[1] - base1, N);
        ch_data[15:8] = 8'h5A;
        base0 = nwr[0]; base1 = nwr[1];
        tick(20);
        chk("mode1_change", 0, nwr[0] - base0, 1);
        chk("mode1_change", 1, nwr[1] - base1, 1);

        // No channel enabled: no strobes.
        mode = 1'b0; ch_en = 4'h0;
        base0 = nwr[0];
        tick(20);
        chk("none_enabled", 0, nwr[0] - base0, 0);

        // Reset in the gap of the gapped instance after several writes.
        ch_en = 4'hF;
        tick(40);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (if1.wr_uart) seen = 1'b1;
            else tick(1);
        end
        chk("gap_strobe_seen", 1, int'(seen), 1);
        tick(1);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("gap_reset_cnt", 1, int'(if1.sent_cnt), 0);
        chk("gap_reset_wd", 1, int'(if1.w_data), 0);
        tick(20);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            tx_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                int c;
                c = $urandom_range(0, N - 1);
                ch_data[c*8 +: 8] = 8'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            if ($urandom_range(0, 39) == 0) ch_en = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(5);
        chk("queue_drained", 0, sbq[0].size(), 0);
        chk("queue_drained", 1, sbq[1].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
